// File: rtl/mem_loader_arbiter.sv
// -----------------------------------------------------------------------------
// mem_loader_arbiter
//
// Purpose:
//   Shares the small program RAM between the CPU datapath and an external
//   byte-stream program loader (UART or switch panel front-end). When the
//   loader asks for the RAM, the CPU is paused at a safe instruction boundary.
//   The loader is then granted the RAM and its bytes are written to
//   auto-incrementing addresses starting at 0. When the session ends, the RAM
//   goes back to the CPU and a one-cycle restart pulse makes the CPU begin
//   again at address 0.
//
// Ports:
//   clk           system clock, all state on the rising edge
//   rst           asynchronous, active-low reset
//   cpu_boundary  controller is in fetch stage 0 (safe boundary)
//   cpu_hlt       CPU halted, treated as a boundary
//   cpu_pause     holds the controller stage counter and PC
//   cpu_restart   one-cycle pulse, resets PC and stage of the CPU
//   ld_req        loader requests the RAM (level, held for the session)
//   ld_gnt        loader owns the RAM
//   ld_valid      ld_data is valid
//   ld_data       byte to write
//   ld_ready      arbiter accepts ld_data this cycle
//   ld_full       sticky: the last session filled the whole RAM
//   mem_sel       RAM port mux, 0 = CPU, 1 = loader
//   mem_addr      loader write address
//   mem_wdata     loader write data
//   mem_we        loader write strobe
//
// Every output comes straight from a flop. The per-state outputs are decoded
// from the next state, so each output is valid during the state it belongs to.
// -----------------------------------------------------------------------------
module mem_loader_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_boundary,
    input  logic              cpu_hlt,
    output logic              cpu_pause,
    output logic              cpu_restart,
    input  logic              ld_req,
    output logic              ld_gnt,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_full,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_GRANT   = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // The last RAM address. Reaching it ends the session, because the counter
    // must never wrap into a second pass.
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                ld_full_q, ld_full_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_pause_q, cpu_pause_d;
    logic                cpu_restart_q, cpu_restart_d;
    logic                ld_gnt_q, ld_gnt_d;
    logic                ld_ready_q, ld_ready_d;
    logic                mem_sel_q, mem_sel_d;
    logic                mem_we_q, mem_we_d;

    // Next-state, address-counter, data-latch and full-flag logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_full_d   = ld_full_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_req) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // If the loader withdraws before a boundary, the CPU was never
                // disturbed, so it is released without a restart.
                if (!ld_req) begin
                    state_d = ST_IDLE;
                end else if (cpu_boundary || cpu_hlt) begin
                    state_d   = ST_GRANT;
                    cnt_d     = CNT_ZERO;
                    ld_full_d = 1'b0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_GRANT: begin
                // An offered byte wins over a falling ld_req, so a last byte
                // that arrives with the drop is still written.
                if (ld_valid && ld_ready_q) begin
                    state_d     = ST_WRITE;
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = ld_data;
                end else if (!ld_req) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    ld_full_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (ld_req) begin
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-state outputs decoded from the next state so that the flops line up with the state
    always_comb begin
        cpu_pause_d   = 1'b0;
        cpu_restart_d = 1'b0;
        ld_gnt_d      = 1'b0;
        ld_ready_d    = 1'b0;
        mem_sel_d     = 1'b0;
        mem_we_d      = 1'b0;
        case (state_d)
            ST_IDLE: begin
                cpu_pause_d = 1'b0;
            end
            ST_DRAIN: begin
                cpu_pause_d = 1'b1;
            end
            ST_GRANT: begin
                cpu_pause_d = 1'b1;
                ld_gnt_d    = 1'b1;
                mem_sel_d   = 1'b1;
                ld_ready_d  = 1'b1;
            end
            ST_WRITE: begin
                cpu_pause_d = 1'b1;
                ld_gnt_d    = 1'b1;
                mem_sel_d   = 1'b1;
                mem_we_d    = 1'b1;
            end
            ST_RELEASE: begin
                // The RAM stays with the loader for this cycle. It moves back
                // to the CPU together with the pause release in IDLE.
                cpu_pause_d   = 1'b1;
                cpu_restart_d = 1'b1;
                ld_gnt_d      = 1'b1;
                mem_sel_d     = 1'b1;
            end
            default: begin
                cpu_pause_d = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset clears everything at once, so a write
    // strobe in flight is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= CNT_ZERO;
            ld_full_q     <= 1'b0;
            mem_addr_q    <= CNT_ZERO;
            mem_wdata_q   <= DATA_ZERO;
            cpu_pause_q   <= 1'b0;
            cpu_restart_q <= 1'b0;
            ld_gnt_q      <= 1'b0;
            ld_ready_q    <= 1'b0;
            mem_sel_q     <= 1'b0;
            mem_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ld_full_q     <= ld_full_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cpu_pause_q   <= cpu_pause_d;
            cpu_restart_q <= cpu_restart_d;
            ld_gnt_q      <= ld_gnt_d;
            ld_ready_q    <= ld_ready_d;
            mem_sel_q     <= mem_sel_d;
            mem_we_q      <= mem_we_d;
        end
    end

    assign cpu_pause   = cpu_pause_q;
    assign cpu_restart = cpu_restart_q;
    assign ld_gnt      = ld_gnt_q;
    assign ld_ready    = ld_ready_q;
    assign ld_full     = ld_full_q;
    assign mem_sel     = mem_sel_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;

endmodule

// File: tb/tb_mem_loader_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_loader_arbiter
//
// Directed testbench for mem_loader_arbiter. Inputs change on the falling
// clock edge. Outputs are checked on the falling edge, where they show the
// state entered at the preceding rising edge.
//
// A small monitor logs every write strobe and every restart cycle. The logged
// entries are compared with hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_loader_arbiter;

    logic       clk;
    logic       rst;
    logic       cpu_boundary;
    logic       cpu_hlt;
    logic       cpu_pause;
    logic       cpu_restart;
    logic       ld_req;
    logic       ld_gnt;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       ld_full;
    logic       mem_sel;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;

    int errors = 0;
    int checks = 0;

    logic [3:0] wr_addr [0:63];
    logic [7:0] wr_data [0:63];
    int         wr_n = 0;
    int         rs_n = 0;
    int         base;
    int         rs0;

    mem_loader_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_boundary (cpu_boundary),
        .cpu_hlt      (cpu_hlt),
        .cpu_pause    (cpu_pause),
        .cpu_restart  (cpu_restart),
        .ld_req       (ld_req),
        .ld_gnt       (ld_gnt),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .ld_full      (ld_full),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log RAM writes and restart cycles as the RAM and CPU would see them
    always @(posedge clk) begin
        if (mem_we === 1'b1 && wr_n < 64) begin
            wr_addr[wr_n] <= mem_addr;
            wr_data[wr_n] <= mem_wdata;
            wr_n          <= wr_n + 1;
        end
        if (cpu_restart === 1'b1) begin
            rs_n <= rs_n + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output vector order: {cpu_pause, cpu_restart, ld_gnt, ld_ready, mem_sel, mem_we}
    task automatic chk_outs(input string tag, input logic [5:0] exp);
        chk(tag, 32'({cpu_pause, cpu_restart, ld_gnt, ld_ready, mem_sel, mem_we}), 32'(exp));
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 32'({cpu_pause, cpu_restart, ld_gnt, ld_ready, ld_full, mem_sel,
                      mem_addr, mem_wdata, mem_we}), 32'd0);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [3:0] a, input logic [7:0] d);
        chk(tag, 32'({wr_addr[idx], wr_data[idx]}), 32'({a, d}));
    endtask

    // Offer a byte until it is accepted. Returns on the falling edge after the
    // accepting rising edge, which means the DUT is in its write cycle.
    task automatic send_byte(input logic [7:0] d);
        bit done;
        done = 1'b0;
        ld_valid = 1'b1;
        ld_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            if (ld_ready === 1'b1) done = 1'b1;
            @(negedge clk);
        end
        ld_valid = 1'b0;
        chk("accept", 32'(done), 32'd1);
    endtask

    initial begin
        rst          = 1'b0;
        cpu_boundary = 1'b0;
        cpu_hlt      = 1'b0;
        ld_req       = 1'b0;
        ld_valid     = 1'b0;
        ld_data      = 8'h00;

        repeat (2) @(negedge clk);
        chk_zero("rst_hold");
        rst = 1'b1;
        @(negedge clk);
        chk_zero("idle_after_rst");

        // Basic load with the boundary already present
        base = wr_n; rs0 = rs_n;
        cpu_boundary = 1'b1;
        ld_req       = 1'b1;
        @(negedge clk); chk_outs("b_drain", 6'b100000);
        @(negedge clk); chk_outs("b_grant", 6'b101110);
        send_byte(8'h15);
        chk_outs("b_write", 6'b101011);
        chk("b_addr0", 32'(mem_addr), 32'd0);
        send_byte(8'h2E);
        send_byte(8'hE0);
        ld_req = 1'b0;
        @(negedge clk); chk_outs("b_release", 6'b111010);
        @(negedge clk); chk_outs("b_idle", 6'b000000);
        chk("b_full", 32'(ld_full), 32'd0);
        chk("b_restarts", 32'(rs_n - rs0), 32'd1);
        chk("b_nwrites", 32'(wr_n - base), 32'd3);
        chk_wr("b_wr0", base + 0, 4'd0, 8'h15);
        chk_wr("b_wr1", base + 1, 4'd1, 8'h2E);
        chk_wr("b_wr2", base + 2, 4'd2, 8'hE0);

        // Drain wait: no grant until the boundary shows up
        cpu_boundary = 1'b0;
        ld_req       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk_outs("dw_wait", 6'b100000);
        end
        cpu_boundary = 1'b1;
        @(negedge clk); chk_outs("dw_grant", 6'b101110);
        send_byte(8'h5A);
        chk("dw_addr0", 32'({mem_addr, mem_wdata}), 32'({4'd0, 8'h5A}));
        @(negedge clk); chk_outs("dw_regrant", 6'b101110);
        ld_req = 1'b0;
        @(negedge clk); chk_outs("dw_release", 6'b111010);
        @(negedge clk); chk_outs("dw_idle", 6'b000000);

        // Abort while draining: no restart, no write
        cpu_boundary = 1'b0;
        rs0 = rs_n; base = wr_n;
        ld_req = 1'b1;
        @(negedge clk); chk_outs("ab_drain1", 6'b100000);
        @(negedge clk); chk_outs("ab_drain2", 6'b100000);
        ld_req = 1'b0;
        @(negedge clk); chk_outs("ab_idle1", 6'b000000);
        @(negedge clk); chk_outs("ab_idle2", 6'b000000);
        chk("ab_restarts", 32'(rs_n - rs0), 32'd0);
        chk("ab_nwrites", 32'(wr_n - base), 32'd0);

        // Fill the whole RAM. The 17th byte must never be taken.
        cpu_boundary = 1'b1;
        ld_req       = 1'b1;
        base = wr_n; rs0 = rs_n;
        repeat (2) @(negedge clk);
        chk_outs("f_grant", 6'b101110);
        for (int k = 0; k < 16; k++) begin
            send_byte(8'(k));
        end
        chk("f_last_addr", 32'({mem_we, mem_addr}), 32'({1'b1, 4'd15}));
        ld_valid = 1'b1;
        ld_data  = 8'h10;
        @(negedge clk); chk_outs("f_release", 6'b111010);
        chk("f_full_set", 32'(ld_full), 32'd1);
        ld_req = 1'b0;
        @(negedge clk); chk_outs("f_idle", 6'b000000);
        repeat (3) @(negedge clk);
        chk_outs("f_idle_hold", 6'b000000);
        ld_valid = 1'b0;
        chk("f_nwrites", 32'(wr_n - base), 32'd16);
        for (int k = 0; k < 16; k++) begin
            chk_wr("f_wr", base + k, 4'(k), 8'(k));
        end
        chk("f_full_sticky", 32'(ld_full), 32'd1);
        chk("f_restarts", 32'(rs_n - rs0), 32'd1);

        // Halt acts as a boundary. The last byte arrives together with the ld_req drop.
        cpu_boundary = 1'b0;
        cpu_hlt      = 1'b1;
        ld_req       = 1'b1;
        base = wr_n;
        repeat (2) @(negedge clk);
        chk_outs("s_grant", 6'b101110);
        chk("s_full_clear", 32'(ld_full), 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        @(negedge clk); chk_outs("s_grant3", 6'b101110);
        ld_valid = 1'b1;
        ld_data  = 8'hAA;
        ld_req   = 1'b0;
        @(negedge clk); chk_outs("s_write", 6'b101011);
        chk("s_addr_data", 32'({mem_addr, mem_wdata}), 32'({4'd3, 8'hAA}));
        ld_valid = 1'b0;
        @(negedge clk); chk_outs("s_release", 6'b111010);
        @(negedge clk); chk_outs("s_idle", 6'b000000);
        chk("s_nwrites", 32'(wr_n - base), 32'd4);
        chk_wr("s_wr3", base + 3, 4'd3, 8'hAA);
        cpu_hlt = 1'b0;

        // Reset in the middle of a write
        cpu_boundary = 1'b1;
        ld_req       = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h11);
        send_byte(8'h77);
        chk("r_in_write", 32'({mem_we, mem_addr}), 32'({1'b1, 4'd1}));
        rs0 = rs_n;
        #2;
        rst    = 1'b0;
        ld_req = 1'b0;
        #1;
        chk_zero("r_async");
        @(negedge clk); chk_zero("r_hold");
        rst = 1'b1;
        @(negedge clk); chk_zero("r_post");
        chk("r_restarts", 32'(rs_n - rs0), 32'd0);
        ld_req = 1'b1;
        repeat (2) @(negedge clk);
        chk_outs("r_grant", 6'b101110);
        send_byte(8'h99);
        chk("r_new_addr0", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 4'd0, 8'h99}));
        ld_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_outs("r_idle", 6'b000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_loader_arbiter.md
# mem_loader_arbiter

Shares the 16-byte program RAM between the CPU datapath and an external byte-stream program loader. It pauses the CPU at an instruction boundary, hands the RAM to the loader, and writes incoming bytes to auto-incrementing addresses. When loading ends, it returns the RAM to the CPU and pulses a restart so the CPU begins at address 0. It sits between the controller/RAM and the loader front-end (UART or switch panel).

## Interface
- ADDR_W, 4, RAM address width; RAM depth is 2^ADDR_W
- DATA_W, 8, RAM/bus data width
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
- cpu_boundary  in  1  high while the controller is in fetch stage 0 (safe instruction boundary)
- cpu_hlt  in  1  CPU halted; treated as a boundary
- cpu_pause  out  1  holds the controller stage counter and PC when high
- cpu_restart  out  1  one-cycle pulse; resets PC and stage of the CPU
- ld_req  in  1  loader requests RAM ownership; level, held for the whole session
- ld_gnt  out  1  loader owns RAM
- ld_valid  in  1  ld_data valid
- ld_data  in  DATA_W  byte to write
- ld_ready  out  1  arbiter accepts ld_data this cycle
- ld_full  out  1  sticky: the last session filled the whole RAM
- mem_sel  out  1  RAM port mux: 0 = CPU, 1 = loader
- mem_addr  out  ADDR_W  loader write address
- mem_wdata  out  DATA_W  loader write data
- mem_we  out  1  loader write strobe

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE, address counter cnt to 0, and ld_full to 0.
- IDLE: mem_sel=0, cpu_pause=0. If ld_req=1, go to DRAIN and set cpu_pause=1.
- DRAIN: cpu_pause=1.
  - If ld_req=0, go to IDLE with no restart.
  - Otherwise, if cpu_boundary|cpu_hlt, go to GRANT. cnt<=0, ld_full<=0, mem_sel<=1, ld_gnt<=1.
- GRANT: ld_ready=1.
  - If ld_valid and ld_ready, latch ld_data into mem_wdata, put cnt on mem_addr, and go to WRITE.
  - Otherwise, if ld_req=0, go to RELEASE.
  - ld_valid and ld_req falling in the same cycle: the byte is accepted, then the write completes, then RELEASE.
- WRITE: mem_we=1 for exactly one cycle and ld_ready=0.
  - If cnt = 2^ADDR_W-1: set ld_full, then go to RELEASE. The counter does not wrap into a second pass.
  - Otherwise: cnt<=cnt+1. Return to GRANT if ld_req=1, else go to RELEASE.
- RELEASE: one cycle. cpu_restart=1 and cpu_pause still 1. mem_sel<=0, ld_gnt<=0, then go to IDLE, where cpu_pause falls.
- Bytes offered while ld_ready=0 (WRITE, DRAIN, RELEASE, IDLE) are not consumed. The loader holds them.
- cpu_boundary is sampled only in DRAIN. A CPU that never reaches a boundary and never halts keeps the arbiter in DRAIN indefinitely (intended; no timeout).
- Reset mid-session (any state): everything returns to reset values immediately. mem_we drops asynchronously and no partial write is left pending. No cpu_restart is issued, because the CPU is reset by the same rst.
- mem_we is never high while mem_sel=0.

## Timing
- Grant latency: ld_req rises at edge N, cpu_pause=1 after N+1. If the boundary is already present, ld_gnt=1 after N+2.
- Throughput: one byte per 2 cycles (GRANT accept, WRITE strobe).
- Write of byte k: mem_addr=k, mem_we=1 in the cycle after its accept edge.
- Release: ld_req falls in GRANT at edge M. RELEASE (cpu_restart=1) follows at M+1, and IDLE (cpu_pause=0, mem_sel=0) at M+2.
- Full: the accept of the 16th byte leads to WRITE at addr 15, then RELEASE, regardless of ld_req.

## Test plan
- Basic load: cpu_boundary=1, ld_req=1, stream 0x15,0x2E,0xE0 -> writes addr0=0x15, addr1=0x2E, addr2=0xE0. Drop ld_req -> one cpu_restart pulse, ld_full=0, mem_sel=0.
- Drain wait: cpu_boundary=0 for 5 cycles after ld_req -> cpu_pause=1, ld_gnt=0 throughout. Boundary rises -> ld_gnt=1 next cycle, cnt=0.
- Fill: stream 17 bytes 0x00..0x10 with ld_req held -> addr 0..15 get 0x00..0x0F, ld_full=1, RELEASE after addr 15. Byte 0x10 is never accepted (ld_ready=0) and no write to addr 0 recurs.
- Abort in DRAIN: ld_req high 2 cycles with cpu_boundary=0, then low -> IDLE, cpu_restart never asserted, mem_we never asserted.
- Simultaneous last byte: ld_valid=1 with data 0xAA and ld_req falling on the same edge in GRANT at cnt=3 -> addr3=0xAA written, then RELEASE.
- Reset mid-WRITE: assert rst low while mem_we=1 -> all outputs 0 immediately, state IDLE. After release from reset, the next session starts at addr 0.
